tcdm_width_downsizer: RTL



---
 rtl/tcdm_width_downsizer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tcdm_width_downsizer.sv
// Wide-to-narrow TCDM converter: serialises one MST_DW request into RATIO SLV_DW beats
// and returns a single reassembled wide response to the master.
module tcdm_width_downsizer #(
    parameter int unsigned AW     = 32,
    parameter int unsigned MST_DW = 64,
    parameter int unsigned SLV_DW = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mst_req_i,
    input  logic [AW-1:0]       mst_add_i,
    input  logic                mst_wen_i,
    input  logic [MST_DW-1:0]   mst_wdata_i,
    input  logic [MST_DW/8-1:0] mst_be_i,
    output logic                mst_gnt_o,
    output logic                mst_r_valid_o,
    output logic [MST_DW-1:0]   mst_r_rdata_o,
    output logic                mst_r_opc_o,
    output logic                slv_req_o,
    output logic [AW-1:0]       slv_add_o,
    output logic                slv_wen_o,
    output logic [SLV_DW-1:0]   slv_wdata_o,
    output logic [SLV_DW/8-1:0] slv_be_o,
    input  logic                slv_gnt_i,
    input  logic                slv_r_valid_i,
    input  logic [SLV_DW-1:0]   slv_r_rdata_i,
    input  logic                slv_r_opc_i
);
    localparam int unsigned RATIO = MST_DW / SLV_DW;
    localparam int unsigned MBE   = MST_DW / 8;
    localparam int unsigned SBE   = SLV_DW / 8;
    localparam int unsigned KW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e            state;
    state_e            state_next;

    logic [AW-1:0]     base_q;
    logic              wen_q;
    logic [MST_DW-1:0] wdata_q;
    logic [MST_DW-1:0] rdata_q;
    logic [MBE-1:0]    be_q;
    logic              opc_q;
    logic [KW-1:0]     beat_q;

    logic              grant;
    logic              has_next;
    logic              first_found;
    logic              wr_found;
    logic [KW-1:0]     first_beat;
    logic [KW-1:0]     next_beat;

    // Gated by reset so every output reads 0 while rst_i is held.
    assign grant = mst_req_i & (state == IDLE) & ~rst_i;

    // Lowest enabled beat of the incoming write, and next enabled beat after the current one.
    always_comb begin
        first_found = 1'b0;
        first_beat  = '0;
        wr_found    = 1'b0;
        next_beat   = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (!first_found && (|mst_be_i[i*SBE +: SBE])) begin
                first_beat  = KW'(i);
                first_found = 1'b1;
            end
            if (!wr_found && (i > int'(beat_q)) && (|be_q[i*SBE +: SBE])) begin
                next_beat = KW'(i);
                wr_found  = 1'b1;
            end
        end
    end

    assign has_next = wen_q ? (beat_q != KW'(RATIO - 1)) : wr_found;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_next = (!mst_wen_i && (mst_be_i == '0)) ? RESP : REQ;
                end
            end
            REQ: begin
                if (slv_gnt_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (slv_r_valid_i) begin
                    state_next = has_next ? REQ : RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mst_gnt_o     = grant;
        mst_r_valid_o = 1'b0;
        mst_r_rdata_o = '0;
        mst_r_opc_o   = 1'b0;
        slv_req_o     = 1'b0;
        slv_add_o     = '0;
        slv_wen_o     = 1'b0;
        slv_wdata_o   = '0;
        slv_be_o      = '0;
        if (state == REQ) begin
            slv_req_o   = 1'b1;
            slv_add_o   = base_q + AW'(beat_q) * AW'(SBE);
            slv_wen_o   = wen_q;
            slv_wdata_o = wdata_q[beat_q*SLV_DW +: SLV_DW];
            slv_be_o    = be_q[beat_q*SBE +: SBE];
        end
        if (state == RESP) begin
            mst_r_valid_o = 1'b1;
            mst_r_rdata_o = rdata_q;
            mst_r_opc_o   = opc_q;
        end
    end

    // Captured request, beat pointer and response accumulators.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            opc_q   <= 1'b0;
            beat_q  <= '0;
        end else if (grant) begin
            base_q  <= mst_add_i & ~AW'(MBE - 1);
            wen_q   <= mst_wen_i;
            wdata_q <= mst_wdata_i;
            be_q    <= mst_be_i;
            opc_q   <= 1'b0;
            rdata_q <= '0;
            beat_q  <= mst_wen_i ? '0 : first_beat;
        end else if ((state == WAIT) && slv_r_valid_i) begin
            if (wen_q) begin
                rdata_q[beat_q*SLV_DW +: SLV_DW] <= slv_r_rdata_i;
            end
            opc_q <= opc_q | slv_r_opc_i;
            if (has_next) begin
                beat_q <= wen_q ? beat_q + KW'(1) : next_beat;
            end
        end
    end

endmodule
